// File: rtl/stack_unit.sv
// Stack-side executor for push/pop/call/ret/returni: owns SP, runs a single-port
// memory request/ack handshake, and returns popped data, PC target and restored flags.
module stack_unit #(
  parameter int                DATA_W = 32,
  parameter int                ADDR_W = 16,
  parameter logic [ADDR_W-1:0] SP_TOP = 16'h00FF,
  parameter int                DEPTH  = 8,
  parameter int                FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [1:0]        sp_sel,
  input  logic              call,
  input  logic              ret,
  input  logic              returni,
  input  logic [DATA_W-1:0] push_data,
  input  logic [DATA_W-1:0] ret_pc,
  input  logic [DATA_W-1:0] call_target,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] pop_data,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_target,
  output logic              flags_load,
  output logic [FLAG_W-1:0] flags_out,
  output logic              err_ovf,
  output logic              err_unf,
  output logic [ADDR_W-1:0] sp
);

  localparam logic [ADDR_W-1:0] SP_FULL = SP_TOP - ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] SP_MIN2 = SP_TOP - ADDR_W'(2);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WR, S_RD1, S_RD2, S_FIN} state_e;
  typedef enum logic [2:0] {OP_PUSH, OP_POP, OP_CALL, OP_RET, OP_RETI} op_e;

  state_e            state;
  op_e               op;
  op_e               req_op;
  logic              req_any;
  logic [DATA_W-1:0] op_data;
  logic [DATA_W-1:0] op_target;

  // Priority decode of the command lines: returni > ret > call > push > pop.
  always_comb begin
    req_any = 1'b1;
    req_op  = OP_POP;
    if (returni)              req_op = OP_RETI;
    else if (ret)             req_op = OP_RET;
    else if (call)            req_op = OP_CALL;
    else if (sp_sel == 2'b01) req_op = OP_PUSH;
    else if (sp_sel == 2'b10) req_op = OP_POP;
    else                      req_any = 1'b0;
  end

  // NOTE: every register here is state, so all updates use non-blocking (<=)
  // assignments; blocking ones would let later statements see half-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op         <= OP_PUSH;
      op_data    <= '0;
      op_target  <= '0;
      sp         <= SP_TOP;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pop_data   <= '0;
      pc_load    <= 1'b0;
      pc_target  <= '0;
      flags_load <= 1'b0;
      flags_out  <= '0;
      err_ovf    <= 1'b0;
      err_unf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid && req_any) begin
            op        <= req_op;
            op_data   <= (req_op == OP_CALL) ? ret_pc : push_data;
            op_target <= call_target;
            busy      <= 1'b1;
            state     <= S_CHECK;
          end
        end

        S_CHECK: begin
          case (op)
            OP_PUSH, OP_CALL: begin
              if (sp == SP_FULL) begin
                err_ovf <= 1'b1;
                done    <= 1'b1;
                state   <= S_FIN;
              end else begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= sp;
                mem_wdata <= op_data;
                state     <= S_WR;
              end
            end
            default: begin
              // returni needs two entries; pop and ret need one.
              if ((op == OP_RETI) ? (sp > SP_MIN2) : (sp == SP_TOP)) begin
                err_unf <= 1'b1;
                done    <= 1'b1;
                state   <= S_FIN;
              end else begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= sp + ADDR_W'(1);
                state    <= S_RD1;
              end
            end
          endcase
        end

        S_WR: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            sp      <= sp - ADDR_W'(1);
            done    <= 1'b1;
            state   <= S_FIN;
            if (op == OP_CALL) begin
              pc_target <= op_target;
              pc_load   <= 1'b1;
            end
          end
        end

        S_RD1: begin
          if (mem_ack) begin
            sp <= sp + ADDR_W'(1);
            if (op == OP_RETI) begin
              // Request stays up; only the address moves to the flag word.
              mem_addr  <= sp + ADDR_W'(2);
              pc_target <= mem_rdata;
              state     <= S_RD2;
            end else begin
              mem_req <= 1'b0;
              done    <= 1'b1;
              state   <= S_FIN;
              if (op == OP_POP) begin
                pop_data <= mem_rdata;
              end else begin
                pc_target <= mem_rdata;
                pc_load   <= 1'b1;
              end
            end
          end
        end

        S_RD2: begin
          if (mem_ack) begin
            sp         <= sp + ADDR_W'(1);
            mem_req    <= 1'b0;
            flags_out  <= mem_rdata[FLAG_W-1:0];
            pc_load    <= 1'b1;
            flags_load <= 1'b1;
            done       <= 1'b1;
            state      <= S_FIN;
          end
        end

        S_FIN: begin
          done       <= 1'b0;
          pc_load    <= 1'b0;
          flags_load <= 1'b0;
          err_ovf    <= 1'b0;
          err_unf    <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
